// File: rtl/gray_frame_engine.sv
// Row-major RGB-to-gray frame engine, two cycles per pixel.
// Optional gray_min/gray_max statistics under `GRAY_STATS_EN.
module gray_frame_engine #(
  parameter int ROWS    = 64,
  parameter int COLS    = 64,
  parameter int CW      = 8,
  parameter int OUT_FMT = 0,
  localparam int RW     = $clog2(ROWS),
  localparam int CLW    = $clog2(COLS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      mode,
  input  logic [3*CW-1:0] in_pix,
  output logic [RW-1:0]   row,
  output logic [CLW-1:0]  col,
  output logic            out_we,
  output logic [3*CW-1:0] out_pix,
  output logic            busy,
  output logic            gray_done
`ifdef GRAY_STATS_EN
  ,
  output logic [CW-1:0]   gray_min,
  output logic [CW-1:0]   gray_max
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [RW-1:0]  LAST_R = RW'(ROWS - 1);
  localparam logic [CLW-1:0] LAST_C = CLW'(COLS - 1);

  state_t r_state, w_next;

  logic [RW-1:0]   r_row;
  logic [CLW-1:0]  r_col;
  logic            r_we;
  logic [3*CW-1:0] r_pix;
  logic            r_busy;
  logic            r_done;
  logic [1:0]      r_mode;

  logic            w_accept;
  logic            w_last;
  logic [CW-1:0]   w_gray;

  function automatic logic [CW-1:0] f_gray(
    input logic [1:0]      m,
    input logic [3*CW-1:0] p
  );
    logic [CW+1:0] r, g, b, mn, mx, s;
    r  = {2'b00, p[3*CW-1:2*CW]};
    g  = {2'b00, p[2*CW-1:CW]};
    b  = {2'b00, p[CW-1:0]};
    mn = r;
    if (g < mn) mn = g;
    if (b < mn) mn = b;
    mx = r;
    if (g > mx) mx = g;
    if (b > mx) mx = b;
    unique case (m)
      2'd0:    s = (mn + mx) >> 1;
      2'd1:    s = (r + (g << 1) + b) >> 2;
      2'd2:    s = mx;
      default: s = mn;
    endcase
    return s[CW-1:0];
  endfunction

  function automatic logic [3*CW-1:0] f_fmt(
    input logic [CW-1:0] gy
  );
    if (OUT_FMT != 0) return {gy, gy, gy};
    return {{CW{1'b0}}, gy, {CW{1'b0}}};
  endfunction

  assign w_gray   = f_gray(r_mode, in_pix);
  assign w_last   = (r_row == LAST_R) && (r_col == LAST_C);
  assign w_accept = start &&
                    (r_state == S_IDLE || r_state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_FETCH;
      S_FETCH: w_next = S_WRITE;
      S_WRITE: w_next = w_last ? S_DONE : S_FETCH;
      S_DONE:  if (start) w_next = S_FETCH;
      default: w_next = S_IDLE;
    endcase
  end

  // Output pixel is formed at the FETCH edge so it is a flop in WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row  <= '0;
      r_col  <= '0;
      r_we   <= 1'b0;
      r_pix  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_mode <= 2'd0;
    end else begin
      r_we  <= 1'b0;
      r_pix <= '0;
      if (w_accept) begin
        r_row  <= '0;
        r_col  <= '0;
        r_mode <= mode;
        r_busy <= 1'b1;
        r_done <= 1'b0;
      end
      if (r_state == S_FETCH) begin
        r_we  <= 1'b1;
        r_pix <= f_fmt(w_gray);
      end
      if (r_state == S_WRITE) begin
        if (w_last) begin
          r_row  <= '0;
          r_col  <= '0;
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end else if (r_col == LAST_C) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

`ifdef GRAY_STATS_EN
  logic [CW-1:0] r_gray;
  logic [CW-1:0] r_min;
  logic [CW-1:0] r_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gray <= '0;
      r_min  <= '0;
      r_max  <= '0;
    end else begin
      if (r_state == S_FETCH) r_gray <= w_gray;
      if (w_accept) begin
        r_min <= '1;
        r_max <= '0;
      end else if (r_state == S_WRITE) begin
        if (r_gray < r_min) r_min <= r_gray;
        if (r_gray > r_max) r_max <= r_gray;
      end
    end
  end

  assign gray_min = r_min;
  assign gray_max = r_max;
`endif

  assign row       = r_row;
  assign col       = r_col;
  assign out_we    = r_we;
  assign out_pix   = r_pix;
  assign busy      = r_busy;
  assign gray_done = r_done;

endmodule

// File: tb/tb_gray_frame_engine.sv
// Directed bench: 4x4 frames on two engines (OUT_FMT 0 and 1).
// Stats ports are checked when GRAY_STATS_EN is defined.
module tb_gray_frame_engine;

  localparam int R  = 4;
  localparam int C  = 4;
  localparam int CW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic [1:0] mode = 2'd0;

  logic [23:0] mem [16];
  logic [1:0]  row0, col0, row1, col1;
  logic        we0, we1, busy0, busy1, done0, done1;
  logic [23:0] pix0, pix1, in0, in1;
`ifdef GRAY_STATS_EN
  logic [7:0]  mn0, mx0, mn1, mx1;
`endif

  int total = 0;
  int bad   = 0;

  logic [23:0] vec [4];
  logic [7:0]  exp_g [4][4];

  always #5 clk = ~clk;

  assign in0 = mem[{row0, col0}];
  assign in1 = mem[{row1, col1}];

  gray_frame_engine #(
    .ROWS(R), .COLS(C), .CW(CW), .OUT_FMT(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mode(mode), .in_pix(in0),
    .row(row0), .col(col0), .out_we(we0),
    .out_pix(pix0), .busy(busy0),
    .gray_done(done0)
`ifdef GRAY_STATS_EN
    , .gray_min(mn0), .gray_max(mx0)
`endif
  );

  gray_frame_engine #(
    .ROWS(R), .COLS(C), .CW(CW), .OUT_FMT(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mode(mode), .in_pix(in1),
    .row(row1), .col(col1), .out_we(we1),
    .out_pix(pix1), .busy(busy1),
    .gray_done(done1)
`ifdef GRAY_STATS_EN
    , .gray_min(mn1), .gray_max(mx1)
`endif
  );

  task automatic init_tables();
    vec[0] = 24'hFF8010;
    vec[1] = 24'h102030;
    vec[2] = 24'h00FF00;
    vec[3] = 24'hC84064;
    // exp_g[vector][mode]
    exp_g[0] = '{8'h87, 8'h83, 8'hFF, 8'h10};
    exp_g[1] = '{8'h20, 8'h20, 8'h30, 8'h10};
    exp_g[2] = '{8'h7F, 8'h7F, 8'hFF, 8'h00};
    exp_g[3] = '{8'h84, 8'h6B, 8'hC8, 8'h40};
    for (int k = 0; k < 16; k++) mem[k] = vec[k % 4];
  endtask

  task automatic start_frame(input logic [1:0] m);
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode  = ~m;
  endtask

  task automatic check_frame(
    input string      nm,
    input logic [7:0] eg [16]
  );
    logic [57:0] got, exp;
    int k;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      k = (c - 1) / 2;
      got = {we0, we1, busy0, busy1, done0, done1,
             row0, col0, pix0, pix1};
      if (c % 2 == 1)
        exp = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
               2'(k / 4), 2'(k % 4), 24'h0, 24'h0};
      else
        exp = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
               2'(k / 4), 2'(k % 4),
               {8'h00, eg[k], 8'h00},
               {eg[k], eg[k], eg[k]}};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL %s cycle %0d: got=%h exp=%h",
                 nm, c, got, exp);
      end
    end
    @(negedge clk);
    got = {we0, we1, busy0, busy1, done0, done1,
           row0, col0, pix0, pix1};
    exp = {6'b000011, 4'h0, 48'h0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s done: got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic run_mode(input logic [1:0] m, input string nm);
    logic [7:0] eg [16];
    for (int k = 0; k < 16; k++) eg[k] = exp_g[k % 4][m];
    start_frame(m);
    check_frame(nm, eg);
  endtask

  task automatic test_reset();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({row0, col0, we0, pix0, busy0, done0} !== 31'h0) begin
      bad++;
      $display("FAIL reset: got=%h exp=0",
               {row0, col0, we0, pix0, busy0, done0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({we0, busy0, done0} !== 3'b000) begin
      bad++;
      $display("FAIL idle: got=%b exp=000", {we0, busy0, done0});
    end
  endtask

  task automatic test_mode0_fmt();
    run_mode(2'd0, "mode0");
  endtask

  task automatic test_modes();
    run_mode(2'd1, "mode1");
    run_mode(2'd2, "mode2");
    run_mode(2'd3, "mode3");
  endtask

  task automatic test_abort();
    start_frame(2'd1);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c == 12) start = 1'b1;
      if (c == 13) begin
        start = 1'b0;
        total++;
        if ({row0, col0, we0, busy0} !== 6'b0110_01) begin
          bad++;
          $display("FAIL start_ignored: got=%b exp=011001",
                   {row0, col0, we0, busy0});
        end
      end
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({row0, col0, we0, pix0, busy0, done0,
         row1, col1, we1, pix1, busy1, done1} !== 62'h0) begin
      bad++;
      $display("FAIL abort_reset: r=%0d c=%0d we=%b busy=%b",
               row0, col0, we0, busy0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({we0, busy0, done0, row0, col0} !== 7'h0) begin
      bad++;
      $display("FAIL post_abort_idle: got=%b exp=0",
               {we0, busy0, done0, row0, col0});
    end
    run_mode(2'd1, "rescan");
  endtask

  task automatic test_restart_stats();
    logic [7:0] eg [16];
    for (int k = 0; k < 16; k++) begin
      eg[k]  = 8'(5 + 5 * k);
      mem[k] = {8'h50, 8'h50, eg[k]};
    end
    start_frame(2'd3);
    check_frame("stats_frame", eg);
`ifdef GRAY_STATS_EN
    total++;
    if ({mn0, mx0, mn1, mx1} !== 32'h0550_0550) begin
      bad++;
      $display("FAIL stats: got=%h exp=05500550",
               {mn0, mx0, mn1, mx1});
    end
`endif
  endtask

  task automatic test_done_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({done0, done1, busy0} !== 3'b000) begin
      bad++;
      $display("FAIL done_reset: got=%b exp=000",
               {done0, done1, busy0});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    init_tables();
    test_reset();
    test_mode0_fmt();
    test_modes();
    test_abort();
    test_restart_stats();
    test_done_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
